// File: rtl/arm_pipe_pkg.sv
// Shared definitions for the ARM pipeline hazard/forwarding control slice.
// Holds the forwarding-mux select encodings, the hazard FSM state type and
// the default register-file geometry (16 registers, r15 = PC).
package arm_pipe_pkg;

  localparam int unsigned ARM_REG_ADDR_W = 4;
  localparam int unsigned ARM_PC_REG     = 15;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_EXMEM   = 2'b01;
  localparam logic [1:0] FWD_MEMWB   = 2'b10;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2
  } hazard_state_t;

endpackage

// File: rtl/hazard_dest_tracker.sv
// Destination tracker for the EX/MEM and MEM/WB stages.
// A two-deep shift register of {rd, we} fed from the instruction leaving EX,
// plus the compare logic that produces the ALU operand forwarding selects.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   idex_rd_i/idex_we_i destination and write enable of the EX instruction
//   idex_rn_i/idex_rm_i source registers of the EX instruction
//   fwd_a_sel_o/_b_sel_o operand A/B source select (FWD_* encoding)
module hazard_dest_tracker
  import arm_pipe_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = ARM_REG_ADDR_W,
  parameter int unsigned PC_REG     = ARM_PC_REG
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] idex_rd_i,
  input  logic                  idex_we_i,
  input  logic [REG_ADDR_W-1:0] idex_rn_i,
  input  logic [REG_ADDR_W-1:0] idex_rm_i,
  output logic [1:0]            fwd_a_sel_o,
  output logic [1:0]            fwd_b_sel_o
);

  localparam logic [REG_ADDR_W-1:0] PC_IDX = REG_ADDR_W'(PC_REG);

  logic [REG_ADDR_W-1:0] exmem_rd_q, memwb_rd_q;
  logic                  exmem_we_q, memwb_we_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exmem_rd_q <= '0;
      exmem_we_q <= 1'b0;
      memwb_rd_q <= '0;
      memwb_we_q <= 1'b0;
    end else begin
      memwb_rd_q <= exmem_rd_q;
      memwb_we_q <= exmem_we_q;
      exmem_rd_q <= idex_rd_i;
      exmem_we_q <= idex_we_i;
    end
  end

  // EX/MEM wins over MEM/WB since it holds the younger result; the PC is
  // never forwarded because its value is produced outside the ALU path.
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] src);
    logic [1:0] sel;
    sel = FWD_REGFILE;
    if (src != PC_IDX) begin
      if (exmem_we_q && (exmem_rd_q == src))
        sel = FWD_EXMEM;
      else if (memwb_we_q && (memwb_rd_q == src))
        sel = FWD_MEMWB;
    end
    return sel;
  endfunction

  assign fwd_a_sel_o = fwd_sel(idex_rn_i);
  assign fwd_b_sel_o = fwd_sel(idex_rm_i);

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// EX-side hazard and forwarding controller.
// Drives the operand forwarding selects, stalls PC and IF/ID with ID/EX
// bubbles on load-use hazards, and flushes IF/ID and ID/EX on a taken
// branch resolved in EX. Stall, bubble and flush are combinational in the
// detecting cycle.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   id_rn/id_rm, *_used        sources read by the instruction in ID
//   idex_rn/rm/rd              sources and destination of the EX instruction
//   idex_reg_write_enable      EX instruction writes a register
//   idex_mem_to_reg_select     EX instruction is a load
//   branch_taken               taken branch resolved in EX
//   pc_write_enable            0 holds the PC
//   ifid_write_enable          0 holds IF/ID
//   ifid_flush                 clears IF/ID to a NOP
//   idex_bubble                zeroes the ID/EX control inputs
//   fwd_a_sel/fwd_b_sel        operand source: 00 regfile, 01 EX/MEM, 10 MEM/WB
// Optional: define HAZARD_STATS_EN to add saturating 16-bit counters
//   stall_count (hazard bubble cycles) and flush_count (flush cycles).
module hazard_fwd_ctrl
  import arm_pipe_pkg::*;
#(
  parameter int unsigned REG_ADDR_W        = ARM_REG_ADDR_W,
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned PC_REG            = ARM_PC_REG
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rn,
  input  logic [REG_ADDR_W-1:0] id_rm,
  input  logic                  id_rn_used,
  input  logic                  id_rm_used,
  input  logic [REG_ADDR_W-1:0] idex_rn,
  input  logic [REG_ADDR_W-1:0] idex_rm,
  input  logic [REG_ADDR_W-1:0] idex_rd,
  input  logic                  idex_reg_write_enable,
  input  logic                  idex_mem_to_reg_select,
  input  logic                  branch_taken,
  output logic                  pc_write_enable,
  output logic                  ifid_write_enable,
  output logic                  ifid_flush,
  output logic                  idex_bubble,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel
`ifdef HAZARD_STATS_EN
 ,output logic [15:0]           stall_count,
  output logic [15:0]           flush_count
`endif
);

  localparam logic [REG_ADDR_W-1:0] PC_IDX       = REG_ADDR_W'(PC_REG);
  localparam logic [2:0]            STALL_RELOAD = 3'(LOAD_STALL_CYCLES - 1);

  hazard_state_t state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          load_use;

  hazard_dest_tracker #(
    .REG_ADDR_W (REG_ADDR_W),
    .PC_REG     (PC_REG)
  ) u_tracker (
    .clk         (clk),
    .rst_n       (reset),
    .idex_rd_i   (idex_rd),
    .idex_we_i   (idex_reg_write_enable),
    .idex_rn_i   (idex_rn),
    .idex_rm_i   (idex_rm),
    .fwd_a_sel_o (fwd_a_sel),
    .fwd_b_sel_o (fwd_b_sel)
  );

  assign load_use = idex_mem_to_reg_select && idex_reg_write_enable &&
                    (idex_rd != PC_IDX) &&
                    ((id_rn_used && (id_rn == idex_rd)) ||
                     (id_rm_used && (id_rm == idex_rd)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    pc_write_enable   = 1'b1;
    ifid_write_enable = 1'b1;
    ifid_flush        = 1'b0;
    idex_bubble       = 1'b0;
    case (state_q)
      RUN: begin
        if (branch_taken) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (load_use) begin
          pc_write_enable   = 1'b0;
          ifid_write_enable = 1'b0;
          idex_bubble       = 1'b1;
          // The detecting cycle is the first bubble; the counter covers the rest.
          if (LOAD_STALL_CYCLES > 1) begin
            cnt_d   = STALL_RELOAD;
            state_d = LOAD_STALL;
          end
        end
      end
      LOAD_STALL: begin
        if (branch_taken) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          cnt_d       = '0;
          state_d     = RUN;
        end else begin
          pc_write_enable   = 1'b0;
          ifid_write_enable = 1'b0;
          idex_bubble       = 1'b1;
          cnt_d             = cnt_q - 3'd1;
          if (cnt_q <= 3'd1)
            state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  // A bubble without a flush can only come from a load-use stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (idex_bubble && !ifid_flush && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 16'd1;
      if (ifid_flush && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
`endif

endmodule
